// File: rtl/mult_tree_pkg.sv
// mult_tree_pkg
// Shared constants and types for the fp64 product-tree gather front end.
//   FP64_ONE        : multiplicative identity used to pad unfilled lanes
//   FP64_EXP_*/MAN_*: IEEE-754 binary64 field boundaries
//   gather_state_t  : FILL (collecting beats) / SEND (presenting a group)
package mult_tree_pkg;

  localparam logic [63:0] FP64_ONE     = 64'h3FF0000000000000;
  localparam int          FP64_EXP_MSB = 62;
  localparam int          FP64_EXP_LSB = 52;
  localparam int          FP64_MAN_MSB = 51;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SEND = 1'b1
  } gather_state_t;

endpackage

// File: rtl/fp64_nan_detect.sv
// fp64_nan_detect
// Combinational NaN classifier for one IEEE-754 double.
// Ports:
//   data   in  64  candidate value
//   is_nan out 1   exponent all ones and mantissa non-zero (quiet or signalling)
module fp64_nan_detect
  import mult_tree_pkg::*;
(
  input  logic [63:0] data,
  output logic        is_nan
);

  // The sign bit does not affect the classification.
  logic unused_sign;
  assign unused_sign = data[63];

  assign is_nan = (&data[FP64_EXP_MSB:FP64_EXP_LSB]) && (|data[FP64_MAN_MSB:0]);

endmodule

// File: rtl/mult_tree_gather.sv
// mult_tree_gather
// Collects a serial stream of fp64 values into NUM parallel lanes and presents
// the whole group in one cycle to the product tree. Lanes not written by the
// stream hold 1.0, so a short group multiplies out to the product of its
// filled lanes only.
//
// Optional feature: define MULT_GATHER_NAN_CHECK_EN to flag groups that
// contained a NaN on m_nan. Without it m_nan is constant 0 and no detector
// is built; the port list is the same either way.
//
// Ports:
//   clk           in   1               rising-edge clock
//   rst           in   1               asynchronous active-high reset
//   s_tdata       in   DATA_WIDTH      stream element
//   s_tvalid      in   1               stream element valid
//   s_tlast       in   1               last element of the group
//   s_tready      out  1               gather accepts (high in FILL only)
//   m_data        out  NUM*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   m_lane_valid  out  NUM             lane k was written by the stream
//   m_tvalid      out  1               group valid, held until m_tready
//   m_tready      in   1               downstream takes the group
//   m_split       out  1               group closed by lane limit, not s_tlast
//   m_nan         out  1               a NaN was accepted into this group
module mult_tree_gather
  import mult_tree_pkg::*;
#(
  parameter int NUM        = 14,
  parameter int DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic [NUM*DATA_WIDTH-1:0] m_data,
  output logic [NUM-1:0]            m_lane_valid,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_split,
  output logic                      m_nan
);

  localparam int              IDX_W    = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM - 1);
  localparam logic [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(FP64_ONE);

  gather_state_t         state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [DATA_WIDTH-1:0] lane_reg [NUM];
  logic [NUM-1:0]        mask_reg;
  logic                  split_reg;

  logic beat;
  logic handshake;

  // Ready and valid depend on state only, so there is no combinational
  // path from s_tvalid to s_tready.
  assign s_tready  = (state_reg == FILL);
  assign m_tvalid  = (state_reg == SEND);
  assign beat      = s_tvalid & s_tready;
  assign handshake = m_tvalid & m_tready;

  // Control: state, write index, split flag.
  // The index returns to 0 as soon as a group closes, so it never has to
  // count past NUM-1 even when NUM is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FILL;
      idx_reg   <= '0;
      split_reg <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (beat) begin
            if (s_tlast || (idx_reg == IDX_LAST)) begin
              state_reg <= SEND;
              idx_reg   <= '0;
              split_reg <= ~s_tlast;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        SEND: begin
          if (m_tready) begin
            state_reg <= FILL;
            split_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= FILL;
          idx_reg   <= '0;
          split_reg <= 1'b0;
        end
      endcase
    end
  end

  // Lane registers and their valid bits. Each lane loads only when the
  // write index points at it and re-pads to 1.0 once the group is taken.
  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg[gi] <= PAD;
          mask_reg[gi] <= 1'b0;
        end else if (handshake) begin
          lane_reg[gi] <= PAD;
          mask_reg[gi] <= 1'b0;
        end else if (beat && (idx_reg == IDX_W'(gi))) begin
          lane_reg[gi] <= s_tdata;
          mask_reg[gi] <= 1'b1;
        end
      end

      assign m_data[gi*DATA_WIDTH +: DATA_WIDTH] = lane_reg[gi];
    end
  endgenerate

  assign m_lane_valid = mask_reg;
  assign m_split      = split_reg;

`ifdef MULT_GATHER_NAN_CHECK_EN
  logic beat_nan;
  logic nan_reg;

  fp64_nan_detect u_nan_detect (
    .data   (s_tdata),
    .is_nan (beat_nan)
  );

  // Sticky for the group being filled; cleared when the group is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_reg <= 1'b0;
    end else if (handshake) begin
      nan_reg <= 1'b0;
    end else if (beat && beat_nan) begin
      nan_reg <= 1'b1;
    end
  end

  assign m_nan = nan_reg;
`else
  assign m_nan = 1'b0;
`endif

endmodule
